winograd_out_writer: RTL and testbench
======================================

// Module: winograd_out_writer
// PURPOSE
//  Downstream stage of the Winograd PE. Accepts one flattened OUT_TILE x OUT_TILE output tile of
//  signed ACC_W-bit results, applies ReLU + rounding right-shift + unsigned saturation to OUT_W bits,
//  and serializes the elements into an output BRAM write port, one element per clock.
//  Tracks the tile index inside a frame so that consecutive tiles land at consecutive addresses.
// PARAMETERS
//  OUT_TILE   2    output tile edge (INPUT_TILE_SIZE-KERNEL_SIZE+1); N = OUT_TILE*OUT_TILE elements
//  ACC_W      29   PE result width (KERNEL_DATA_WIDTH+INPUT_DATA_WIDTH+13), two's complement
//  OUT_W      8    quantized output width, unsigned
//  ADDR_W     8    output BRAM address width
//  NUM_TILES  16   tiles per frame; elaboration error if NUM_TILES*N > 2**ADDR_W
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset      in   1          asynchronous, active-high
//  in_valid   in   1          tile present on in_data (driven from the PE finalFlatten strobe)
//  in_ready   out  1          stage can accept a tile this cycle
//  in_data    in   N*ACC_W    tile; element k = in_data[(N*ACC_W-1)-k*ACC_W -: ACC_W] (element 0 in MSBs)
//  cfg_shift  in   5          right-shift amount, sampled on tile acceptance; legal 0..ACC_W-1
//  bram_en    out  1          output BRAM enable
//  bram_we    out  1          output BRAM write enable
//  bram_addr  out  ADDR_W     write address
//  bram_din   out  OUT_W      write data
//  tile_done  out  1          one-cycle pulse coincident with the last element write of a tile
//  frame_done out  1          one-cycle pulse coincident with last write of tile NUM_TILES-1
// BEHAVIOUR
//  - Reset (async): state=IDLE, elem_cnt=0, tile_cnt=0, base=0; bram_en/we/addr/din, tile_done,
//    frame_done all 0. Reset mid-tile abandons the tile immediately; no further writes from it.
//  - States: IDLE, WRITE. in_ready = (IDLE) | (WRITE & elem_cnt==N-1) (combinational from state).
//  - Accept = in_valid & in_ready: latch in_data and cfg_shift into tile_q/shift_q, elem_cnt<=0, go WRITE.
//  - WRITE, each cycle (registered outputs): bram_en=bram_we=1, bram_addr=base+elem_cnt,
//    bram_din=quant(tile_q[elem_cnt]); elem_cnt++. Latency: element 0 written in the cycle after accept.
//  - On elem_cnt==N-1: tile_done=1; base+=N; tile_cnt++. If tile_cnt==NUM_TILES-1: frame_done=1,
//    base<=0, tile_cnt<=0. Then WRITE again if a tile was accepted this cycle (back-to-back, no bubble,
//    N cycles/tile), else IDLE with bram_en/we deasserted.
//  - in_valid while in_ready=0 is ignored (the PE holds outData stable; no loss, no queue).
//  - quant(v): v<0 -> 0. Else r = (v + (shift_q ? 1<<(shift_q-1) : 0)) >> shift_q, computed in ACC_W+1
//    bits (no overflow); r > 2**OUT_W-1 -> 2**OUT_W-1, else r[OUT_W-1:0].
//  - Writes are never issued outside WRITE; bram_addr never exceeds NUM_TILES*N-1.
// STRUCTURE
//  - Shared package winograd_pkg: OUT_TILE/N and ACC_W derivation functions, element slice helper,
//    state encoding localparams for IDLE/WRITE.
//  - One sub-module: winograd_out_quant (combinational ReLU/round/saturate, params ACC_W, OUT_W),
//    instantiated once on the muxed element; FSM, counters and address gen stay in this module.
// TESTING
//  1 Reset asserted, then released -> all outputs 0, in_ready=1, no bram_we for 10 idle cycles.
//  2 Tile {300,-5,128,70000}, shift=1 -> addr 0..3 data 150,0,64,255; tile_done on addr-3 cycle.
//  3 Tile {0,255,256,-1}, shift=0 -> data 0,255,255,0; rounding term 0.
//  4 in_valid held for 2 tiles -> 8 consecutive write cycles addr 0..7, no gap, tile_done on 4th and 8th.
//  5 NUM_TILES=16, 17 tiles -> frame_done with write to addr 63; 17th tile writes addr 0..3.
//  6 reset pulsed during element 2 write -> bram_we drops asynchronously; next tile writes from addr 0.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd PE output path: geometry helpers,
// flattened-tile slicing and the writer FSM state encoding.
package winograd_pkg;

    localparam logic STATE_IDLE  = 1'b0;
    localparam logic STATE_WRITE = 1'b1;

    typedef enum logic {
        IDLE  = STATE_IDLE,
        WRITE = STATE_WRITE
    } state_t;

    // Output tile edge from the input tile edge and kernel edge.
    function automatic int out_tile_size(input int in_tile, input int kernel);
        return in_tile - kernel + 1;
    endfunction

    // Element count of a square output tile.
    function automatic int tile_elems(input int out_tile);
        return out_tile * out_tile;
    endfunction

    // PE accumulator width; 13 guard bits cover the transform growth.
    function automatic int acc_width(input int kernel_w, input int input_w);
        return kernel_w + input_w + 13;
    endfunction

    // LSB position of element k in a flattened tile (element 0 in the MSBs).
    function automatic int elem_lsb(input int n, input int acc_w, input int k);
        return (n - 1 - k) * acc_w;
    endfunction

    // Counter width that stays legal for a count of one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/winograd_out_quant.sv
// Combinational quantizer: ReLU, round-half-up right shift, unsigned saturation.
module winograd_out_quant
    import winograd_pkg::*;
#(
    parameter int ACC_W = 29,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] value,
    input  logic [4:0]       shift,
    output logic [OUT_W-1:0] q
);

    // One extra bit keeps the rounding add from wrapping on the largest positive input.
    localparam logic [ACC_W:0] SAT_MAX = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [ACC_W:0] round_term;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] shifted;

    // Negative inputs clamp to zero; positive ones are rounded, shifted and saturated.
    always_comb begin
        round_term = '0;
        if (shift != 5'd0) begin
            round_term = (ACC_W + 1)'(1) << (shift - 5'd1);
        end
        sum     = {1'b0, value} + round_term;
        shifted = sum >> shift;
        if (value[ACC_W-1]) begin
            q = '0;
        end else if (shifted > SAT_MAX) begin
            q = '1;
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/winograd_out_writer.sv
// Serializes quantized Winograd output tiles into an output BRAM, one element
// per clock, with consecutive tiles of a frame at consecutive addresses.
//
//   state | meaning
//   IDLE  | no tile held; ready for a new one, BRAM port quiet
//   WRITE | writing element elem_cnt of tile_q; ready again on the last element
module winograd_out_writer
    import winograd_pkg::*;
#(
    parameter int OUT_TILE  = 2,
    parameter int ACC_W     = 29,
    parameter int OUT_W     = 8,
    parameter int ADDR_W    = 8,
    parameter int NUM_TILES = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [tile_elems(OUT_TILE)*ACC_W-1:0]   in_data,
    input  logic [4:0]                              cfg_shift,
    output logic                                    bram_en,
    output logic                                    bram_we,
    output logic [ADDR_W-1:0]                       bram_addr,
    output logic [OUT_W-1:0]                        bram_din,
    output logic                                    tile_done,
    output logic                                    frame_done
);

    localparam int N      = tile_elems(OUT_TILE);
    localparam int CNT_W  = cnt_width(N);
    localparam int TILE_W = cnt_width(NUM_TILES);

    if (NUM_TILES * N > 2 ** ADDR_W) begin : g_bad_cfg
        $error("winograd_out_writer: NUM_TILES*N exceeds the BRAM address space");
    end

    state_t              state;
    logic [CNT_W-1:0]    elem_cnt;
    logic [TILE_W-1:0]   tile_cnt;
    logic [ADDR_W-1:0]   base;
    logic [N*ACC_W-1:0]  tile_q;
    logic [4:0]          shift_q;
    logic [ACC_W-1:0]    elems [N];
    logic [ACC_W-1:0]    cur_elem;
    logic [OUT_W-1:0]    cur_q;
    logic                last_elem;
    logic                accept;

    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign elems[k] = tile_q[elem_lsb(N, ACC_W, k) +: ACC_W];
    end

    assign cur_elem  = elems[elem_cnt];
    assign last_elem = (elem_cnt == CNT_W'(N - 1));
    assign in_ready  = (state == IDLE) || ((state == WRITE) && last_elem);
    assign accept    = in_valid && in_ready;

    winograd_out_quant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_quant (
        .value (cur_elem),
        .shift (shift_q),
        .q     (cur_q)
    );

    // Tile capture, element sequencing, tile/frame address tracking and BRAM port registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            elem_cnt   <= '0;
            tile_cnt   <= '0;
            base       <= '0;
            tile_q     <= '0;
            shift_q    <= '0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            tile_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tile_done  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                tile_q  <= in_data;
                shift_q <= cfg_shift;
            end
            case (state)
                IDLE: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                    if (accept) begin
                        elem_cnt <= '0;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    bram_en   <= 1'b1;
                    bram_we   <= 1'b1;
                    bram_addr <= base + ADDR_W'(elem_cnt);
                    bram_din  <= cur_q;
                    if (last_elem) begin
                        tile_done <= 1'b1;
                        elem_cnt  <= '0;
                        if (tile_cnt == TILE_W'(NUM_TILES - 1)) begin
                            frame_done <= 1'b1;
                            base       <= '0;
                            tile_cnt   <= '0;
                        end else begin
                            base     <= base + ADDR_W'(N);
                            tile_cnt <= tile_cnt + 1'b1;
                        end
                        state <= accept ? WRITE : IDLE;
                    end else begin
                        elem_cnt <= elem_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_winograd_out_writer.sv
// Bench for winograd_out_writer: directed table, back-to-back, frame wrap,
// mid-tile reset and randomized tiles against an arithmetic reference.
module tb_winograd_out_writer;

    localparam int ACC_W     = 29;
    localparam int OUT_W     = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_TILES = 16;
    localparam int N         = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*ACC_W-1:0]   in_data = '0;
    logic [4:0]           cfg_shift = '0;
    logic                 bram_en, bram_we, tile_done, frame_done;
    logic [ADDR_W-1:0]    bram_addr;
    logic [OUT_W-1:0]     bram_din;

    winograd_out_writer #(
        .OUT_TILE(2), .ACC_W(ACC_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .NUM_TILES(NUM_TILES)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .cfg_shift(cfg_shift), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .tile_done(tile_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OUT_W-1:0]  data;
        logic              td;
        logic              fd;
    } wr_t;

    typedef struct packed {
        logic [0:N-1][ACC_W-1:0] elems;
        logic [4:0]              shift;
        logic [0:N-1][OUT_W-1:0] exp;
    } vec_t;

    int  checks = 0;
    int  failures = 0;
    int  model_tile = 0;
    int  fd_seen = 0;
    int  last_addr = -1;
    wr_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] ref_quant(input logic [ACC_W-1:0] v, input int s);
        longint x;
        x = longint'($signed(v));
        if (x < 0) return '0;
        if (s > 0) x = x + (longint'(1) << (s - 1));
        x = x >> s;
        if (x > 255) return 8'd255;
        return x[OUT_W-1:0];
    endfunction

    // Queue the four writes a tile should produce at the model's current frame position.
    task automatic expect_tile(input logic [0:N-1][OUT_W-1:0] d);
        wr_t w;
        for (int k = 0; k < N; k++) begin
            w.addr = ADDR_W'(model_tile * N + k);
            w.data = d[k];
            w.td   = (k == N - 1);
            w.fd   = (k == N - 1) && (model_tile == NUM_TILES - 1);
            exp_q.push_back(w);
        end
        model_tile = (model_tile + 1) % NUM_TILES;
    endtask

    function automatic logic [0:N-1][OUT_W-1:0] model_tile_out(input logic [0:N-1][ACC_W-1:0] e, input int s);
        logic [0:N-1][OUT_W-1:0] r;
        for (int k = 0; k < N; k++) r[k] = ref_quant(e[k], s);
        return r;
    endfunction

    // Called at a negedge; holds the tile until the DUT takes it, returns at the next negedge.
    task automatic drive_tile(input logic [0:N-1][ACC_W-1:0] e, input logic [4:0] s);
        int w = 0;
        in_valid  = 1'b1;
        in_data   = e;
        cfg_shift = s;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("drain_remaining", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        model_tile = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [ACC_W-1:0] rand_elem();
        case ($urandom_range(0, 3))
            0:       return ACC_W'($urandom_range(0, 1000));
            1:       return ACC_W'(-longint'($urandom_range(1, 100000)));
            2:       return ACC_W'($urandom_range(0, 32'h0FFF_FFFF));
            default: return ACC_W'($urandom);
        endcase
    endfunction

    // Scoreboard: every write must match the head of the expected stream.
    always @(negedge clk) begin
        if (!reset) begin
            if (bram_en != bram_we) check("en_equals_we", bram_en, bram_we);
            if (!bram_we && (tile_done || frame_done)) check("done_without_write", 1, 0);
            if (bram_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", bram_addr, -1);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    check("write_addr", bram_addr, w.addr);
                    check("write_data", bram_din, w.data);
                    check("tile_done", tile_done, w.td);
                    check("frame_done", frame_done, w.fd);
                end
                if (frame_done) fd_seen++;
                last_addr = bram_addr;
            end
        end
    end

    vec_t tbl[5];

    initial begin
        tbl[0] = '{elems: {29'sd300, -29'sd5, 29'sd128, 29'sd70000}, shift: 5'd1,
                   exp: {8'd150, 8'd0, 8'd64, 8'd255}};
        tbl[1] = '{elems: {29'sd0, 29'sd255, 29'sd256, -29'sd1}, shift: 5'd0,
                   exp: {8'd0, 8'd255, 8'd255, 8'd0}};
        tbl[2] = '{elems: {-29'sd100, 29'sd15, 29'sd8, 29'sd4096}, shift: 5'd4,
                   exp: {8'd0, 8'd1, 8'd1, 8'd255}};
        tbl[3] = '{elems: {29'sd268435455, 29'sd134217728, 29'sd134217727, -29'sd268435456}, shift: 5'd28,
                   exp: {8'd1, 8'd1, 8'd0, 8'd0}};
        tbl[4] = '{elems: {29'sd383, 29'sd384, 29'sd65407, 29'sd65408}, shift: 5'd8,
                   exp: {8'd1, 8'd2, 8'd255, 8'd255}};

        // Reset state and quiet idle period.
        repeat (3) @(negedge clk);
        check("reset_bram_we", bram_we, 0);
        check("reset_tile_done", tile_done, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_outputs", {bram_en, bram_we, bram_addr, bram_din, tile_done, frame_done}, 0);
        begin
            int we_cnt = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bram_we) we_cnt++;
            end
            check("idle_we_count", we_cnt, 0);
        end

        // Directed table: each tile isolated, addresses continue across tiles.
        for (int i = 0; i < 5; i++) begin
            expect_tile(tbl[i].exp);
            drive_tile(tbl[i].elems, tbl[i].shift);
            wait_drain();
        end

        // Two tiles back to back: eight uninterrupted write cycles.
        do_reset();
        begin
            int run = 0;
            expect_tile(tbl[0].exp);
            expect_tile(tbl[4].exp);
            fork
                begin
                    drive_tile(tbl[0].elems, tbl[0].shift);
                    drive_tile(tbl[4].elems, tbl[4].shift);
                end
                begin
                    int w = 0;
                    while (!bram_we && w < 10) begin
                        @(negedge clk);
                        w++;
                    end
                    while (bram_we && run < 20) begin
                        run++;
                        @(negedge clk);
                    end
                end
            join
            check("b2b_run_length", run, 8);
            wait_drain();
        end

        // Frame wrap: 17 tiles, frame_done once at addr 63, 17th tile back at addr 0..3.
        do_reset();
        fd_seen = 0;
        for (int t = 0; t < 17; t++) begin
            logic [0:N-1][ACC_W-1:0] e;
            int s;
            for (int k = 0; k < N; k++) e[k] = rand_elem();
            s = $urandom_range(0, 28);
            expect_tile(model_tile_out(e, s));
            drive_tile(e, 5'(s));
        end
        wait_drain();
        check("frame_done_count", fd_seen, 1);
        check("tile17_last_addr", last_addr, 3);

        // Reset during the element-2 write abandons the tile at once.
        do_reset();
        expect_tile(tbl[2].exp);
        drive_tile(tbl[2].elems, tbl[2].shift);
        begin
            int w = 0;
            while (!(bram_we && bram_addr == 8'd2) && w < 20) begin
                @(negedge clk);
                w++;
            end
            check("elem2_seen", bram_we && bram_addr == 8'd2, 1);
        end
        reset = 1'b1;
        exp_q.delete();
        model_tile = 0;
        #1;
        check("async_reset_we", bram_we, 0);
        check("async_reset_tile_done", tile_done, 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int we_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (bram_we) we_cnt++;
            end
            check("post_reset_quiet", we_cnt, 0);
        end
        expect_tile(tbl[1].exp);
        drive_tile(tbl[1].elems, tbl[1].shift);
        wait_drain();

        // Randomized tiles with random gaps, compared against the reference model.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            logic [0:N-1][ACC_W-1:0] e;
            int s;
            for (int k = 0; k < N; k++) e[k] = rand_elem();
            s = $urandom_range(0, 28);
            expect_tile(model_tile_out(e, s));
            drive_tile(e, 5'(s));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
